// File: rtl/efp_lut_responder.sv
// efp_lut_responder: round-robin lookup server for the EFP lanes.
// One shared dual-port table RAM, registered per-lane result and pulse.
module efp_lut_responder #(
  parameter int LANES    = 24,
  parameter int AW       = 11,
  parameter int DW       = 11,
  parameter int RD_PORTS = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [LANES-1:0] req_valid,
  input  logic [AW-1:0]    addra [LANES-1:0],
  output logic [DW-1:0]    result_bin [LANES-1:0],
  output logic [LANES-1:0] resp_valid,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [DW-1:0]    wr_data,
  output logic             busy,
  output logic [15:0]      served_cnt
);
  localparam int PW    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int DEPTH = 1 << AW;

  logic [DW-1:0]    mem [DEPTH];
  logic [PW-1:0]    rr;
  logic [PW-1:0]    rr_nxt;
  logic [PW-1:0]    last_idx;
  logic [LANES-1:0] inflight;
  logic [LANES-1:0] inflight_nxt;
  logic [LANES-1:0] pending;
  logic             two;
  logic             g0_v;
  logic             g1_v;
  logic [PW-1:0]    g0_idx;
  logic [PW-1:0]    g1_idx;
  logic             pa_v;
  logic             pb_v;
  logic [PW-1:0]    pa_idx;
  logic [PW-1:0]    pb_idx;
  logic             va;
  logic             vb;
  logic [PW-1:0]    la;
  logic [PW-1:0]    lb;
  logic [DW-1:0]    qa;
  logic [DW-1:0]    qb;

  // a lane pulsing resp_valid is not regranted in that cycle
  assign pending = req_valid & ~inflight & ~resp_valid;
  // a write occupies port A, leaving one read slot
  assign two = (RD_PORTS >= 2) && !wr_en;

  // scan from rr with explicit wrap at LANES, pick first one or two
  always_comb begin
    logic [PW:0]   sum;
    logic [PW-1:0] sel;
    sum    = '0;
    sel    = '0;
    g0_v   = 1'b0;
    g1_v   = 1'b0;
    g0_idx = '0;
    g1_idx = '0;
    for (int k = 0; k < LANES; k++) begin
      sum = {1'b0, rr} + (PW+1)'(k);
      if (sum >= (PW+1)'(LANES)) sum = sum - (PW+1)'(LANES);
      sel = sum[PW-1:0];
      if (pending[sel]) begin
        if (!g0_v) begin
          g0_v   = 1'b1;
          g0_idx = sel;
        end else if (!g1_v && two) begin
          g1_v   = 1'b1;
          g1_idx = sel;
        end
      end
    end
  end

  // with a write on A the single read goes to port B (old data on collision)
  assign pa_v   = g0_v & ~wr_en;
  assign pa_idx = g0_idx;
  assign pb_v   = wr_en ? g0_v : g1_v;
  assign pb_idx = wr_en ? g0_idx : g1_idx;

  // pointer moves past the last lane granted this cycle
  always_comb begin
    last_idx = g1_v ? g1_idx : g0_idx;
    if (last_idx == PW'(LANES - 1)) rr_nxt = '0;
    else rr_nxt = last_idx + 1'b1;
  end

  // retire last cycle's reads, mark this cycle's grants
  always_comb begin
    inflight_nxt = inflight;
    if (va) inflight_nxt[la] = 1'b0;
    if (vb) inflight_nxt[lb] = 1'b0;
    if (pa_v) inflight_nxt[pa_idx] = 1'b1;
    if (pb_v) inflight_nxt[pb_idx] = 1'b1;
  end

  // table RAM: port A writes, both ports read synchronously, never reset
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    qa <= mem[addra[pa_idx]];
    qb <= mem[addra[pb_idx]];
  end

  // lane pipeline, result capture, response pulse and counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      va         <= 1'b0;
      vb         <= 1'b0;
      la         <= '0;
      lb         <= '0;
      inflight   <= '0;
      resp_valid <= '0;
      rr         <= '0;
      busy       <= 1'b0;
      served_cnt <= '0;
      for (int i = 0; i < LANES; i++) result_bin[i] <= '0;
    end else begin
      va         <= pa_v;
      vb         <= pb_v;
      la         <= pa_idx;
      lb         <= pb_idx;
      inflight   <= inflight_nxt;
      resp_valid <= '0;
      if (va) begin
        result_bin[la] <= qa;
        resp_valid[la] <= 1'b1;
      end
      if (vb) begin
        result_bin[lb] <= qb;
        resp_valid[lb] <= 1'b1;
      end
      if (g0_v) rr <= rr_nxt;
      busy       <= (|pending) | (|inflight);
      served_cnt <= served_cnt + {15'd0, va} + {15'd0, vb};
    end
  end
endmodule
